// File: rtl/jtkiwi_romcache.sv
// jtkiwi_romcache
// Two-entry read cache plus SDRAM request sequencer for one kiwi gfx fetch
// port (tile or sprite). Repeated ROM words are answered from local
// registers; each miss issues exactly one SDRAM request. o_ok is high only
// when o_dout holds the word for the current i_addr.
//
// Ports
//   i_clk      system clock
//   i_rst      asynchronous, active-high reset
//   i_clr      invalidate both entries (ROM download / bank switch)
//   i_cs       fetch request from gfx
//   i_addr     word address from gfx
//   o_ok       o_dout valid for the current address
//   o_dout     cached or fetched word
//   o_sd_req   SDRAM request level
//   o_sd_addr  SDRAM word address, stable while o_sd_req is high
//   i_sd_ack   one-cycle strobe: request accepted
//   i_sd_dst   one-cycle strobe: i_sd_din valid
//   i_sd_din   SDRAM read data
module jtkiwi_romcache #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_cs,
    input  logic [AW-1:0] i_addr,
    output logic          o_ok,
    output logic [DW-1:0] o_dout,
    output logic          o_sd_req,
    output logic [AW-1:0] o_sd_addr,
    input  logic          i_sd_ack,
    input  logic          i_sd_dst,
    input  logic [DW-1:0] i_sd_din
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [1:0]           r_valid;
    logic [1:0][AW-1:0]   r_tag;
    logic [1:0][DW-1:0]   r_data;
    logic                 r_lru;      // entry to replace on the next fill
    logic [AW-1:0]        r_fa;       // address of the fetch in flight
    logic                 r_ok;
    logic [DW-1:0]        r_dout;

    logic                 w_match0;
    logic                 w_match1;
    logic                 w_fill;
    logic                 w_fill_keep;
    logic                 w_hit;
    logic                 w_hit_idx;
    logic                 w_fwd;
    logic                 w_start;
    logic                 w_sd_req;

    // Lookup: full-width tag compare against both entries
    always_comb begin
        w_match0    = r_valid[0] && (r_tag[0] == i_addr);
        w_match1    = r_valid[1] && (r_tag[1] == i_addr);
        w_hit_idx   = w_match1;
        // A strobe counts as a fill only while a fetch is outstanding; a
        // data strobe that beats the ack in REQ still completes the fetch.
        w_fill      = i_sd_dst && ((r_state == REQ) || (r_state == WAIT));
        // Data landing together with clr belongs to the old ROM contents.
        w_fill_keep = w_fill && !i_clr;
        // The fill cycle owns the storage, so lookups are not answered then.
        w_hit       = i_cs && (w_match0 || w_match1) && !w_fill && !i_clr;
        w_fwd       = w_fill_keep && i_cs && (i_addr == r_fa);
        w_start     = (r_state == IDLE) && i_cs && !w_match0 && !w_match1 && !i_clr;
    end

    // Sequencer: next state and request level
    always_comb begin
        w_state_nx = r_state;
        w_sd_req   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_nx = REQ;
            end
            REQ: begin
                w_sd_req = 1'b1;
                if (i_sd_dst)      w_state_nx = IDLE;
                else if (i_sd_ack) w_state_nx = WAIT;
            end
            WAIT: begin
                if (i_sd_dst) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Registered control: state, valid bits, LRU, output word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_valid <= 2'b00;
            r_lru   <= 1'b0;
            r_fa    <= '0;
            r_ok    <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) r_fa <= i_addr;

            if (i_clr) begin
                r_valid <= 2'b00;
            end else if (w_fill_keep) begin
                r_valid[r_lru] <= 1'b1;
            end

            if (w_fill_keep) begin
                r_lru <= ~r_lru;
            end else if (w_hit) begin
                r_lru <= ~w_hit_idx;
            end

            r_ok <= w_fwd || w_hit;
            if (w_fwd) begin
                r_dout <= i_sd_din;
            end else if (w_hit) begin
                r_dout <= r_data[w_hit_idx];
            end
        end
    end

    // Entry storage: meaningful only where the matching valid bit is set
    always_ff @(posedge i_clk) begin
        if (w_fill_keep) begin
            r_tag[r_lru]  <= r_fa;
            r_data[r_lru] <= i_sd_din;
        end
    end

    assign o_ok      = r_ok;
    assign o_dout    = r_dout;
    assign o_sd_req  = w_sd_req;
    assign o_sd_addr = r_fa;

endmodule

// File: tb/tb_jtkiwi_romcache.sv
module tb_jtkiwi_romcache;

    localparam int AW = 18;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          cs = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          ok;
    logic [DW-1:0] dout;
    logic          sd_req;
    logic [AW-1:0] sd_addr;
    logic          sd_ack = 1'b0;
    logic          sd_dst = 1'b0;
    logic [DW-1:0] sd_din = '0;

    jtkiwi_romcache #(.AW(AW), .DW(DW)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clr    (clr),
        .i_cs     (cs),
        .i_addr   (addr),
        .o_ok     (ok),
        .o_dout   (dout),
        .o_sd_req (sd_req),
        .o_sd_addr(sd_addr),
        .i_sd_ack (sd_ack),
        .i_sd_dst (sd_dst),
        .i_sd_din (sd_din)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Rising edges of the request line seen by the bench
    int  req_rises = 0;
    bit  prev_req = 1'b0;
    always @(negedge clk) begin
        if (sd_req && !prev_req) req_rises++;
        prev_req = sd_req;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: MRU-ordered list of at most two words, plus the
    // single outstanding fetch described by its address and ack status.
    typedef struct {
        logic [AW-1:0] tag;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    bit            m_busy;
    bit            m_acked;
    logic [AW-1:0] m_fa;
    bit            m_ok;
    logic [DW-1:0] m_dout;

    task automatic model_reset();
        mq.delete();
        m_busy  = 0;
        m_acked = 0;
        m_fa    = '0;
        m_ok    = 0;
        m_dout  = '0;
    endtask

    task automatic model_step(input bit c, input logic [AW-1:0] a, input bit cl,
                              input bit ack, input bit dst, input logic [DW-1:0] din);
        bit   fill;
        bit   hit;
        bit   start;
        int   idx;
        ent_t e;
        fill = m_busy && dst;
        idx  = -1;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == a) idx = i;
        hit   = c && !cl && !fill && (idx >= 0);
        start = !m_busy && c && !cl && (idx < 0);

        if (cl) m_ok = 0;
        else if (fill && c && a == m_fa) begin m_ok = 1; m_dout = din; end
        else if (hit) begin m_ok = 1; m_dout = mq[idx].data; end
        else m_ok = 0;

        if (cl) mq.delete();
        else if (fill) begin
            if (mq.size() == 2) void'(mq.pop_back());
            e.tag = m_fa; e.data = din;
            mq.push_front(e);
        end else if (hit) begin
            e = mq[idx];
            mq.delete(idx);
            mq.push_front(e);
        end

        if (fill) m_busy = 0;
        else if (m_busy && !m_acked && ack) m_acked = 1;
        else if (start) begin m_busy = 1; m_acked = 0; m_fa = a; end
    endtask

    // One clock: drive inputs, clock, then sample 1 ns after the edge
    task automatic step(input bit c, input logic [AW-1:0] a, input bit cl,
                        input bit ack, input bit dst, input logic [DW-1:0] din,
                        input bit mchk);
        cs = c; addr = a; clr = cl; sd_ack = ack; sd_dst = dst; sd_din = din;
        @(posedge clk);
        #1;
        model_step(c, a, cl, ack, dst, din);
        if (mchk) begin
            chk("model_ok",      {31'd0, ok},           {31'd0, m_ok});
            chk("model_dout",    dout,                  m_dout);
            chk("model_sd_req",  {31'd0, sd_req},       {31'd0, (m_busy && !m_acked)});
            chk("model_sd_addr", {{(32-AW){1'b0}}, sd_addr}, {{(32-AW){1'b0}}, m_fa});
        end
        cs = 0; sd_ack = 0; sd_dst = 0; clr = 0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1, a, 0, 0, 0, '0, 1);
        step(1, a, 0, 1, 0, '0, 1);
        step(1, a, 0, 0, 1, d, 1);
    endtask

    typedef struct {
        bit            cs;
        logic [AW-1:0] addr;
        bit            clr;
        bit            ack;
        bit            dst;
        logic [DW-1:0] din;
        bit            e_ok;
        logic [DW-1:0] e_dout;
        bit            e_req;
        logic [AW-1:0] e_saddr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises0;
        logic [AW-1:0] ra;
        bit rc, rcl, rack, rdst;

        // Reset then miss, as explicit vectors
        vecs[0] = '{1, 18'h00100, 0, 0, 0, 32'h0,        0, 32'h0,        1, 18'h00100};
        vecs[1] = '{1, 18'h00100, 0, 0, 0, 32'h0,        0, 32'h0,        1, 18'h00100};
        vecs[2] = '{1, 18'h00100, 0, 0, 0, 32'h0,        0, 32'h0,        1, 18'h00100};
        vecs[3] = '{1, 18'h00100, 0, 1, 0, 32'h0,        0, 32'h0,        0, 18'h00100};
        vecs[4] = '{1, 18'h00100, 0, 0, 0, 32'h0,        0, 32'h0,        0, 18'h00100};
        vecs[5] = '{1, 18'h00100, 0, 0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 18'h00100};
        vecs[6] = '{1, 18'h00100, 0, 0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 18'h00100};
        vecs[7] = '{0, 18'h00100, 0, 0, 0, 32'h0,        0, 32'hDEADBEEF, 0, 18'h00100};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ok",      {31'd0, ok},     32'd0);
        chk("reset_dout",    dout,            32'd0);
        chk("reset_sd_req",  {31'd0, sd_req}, 32'd0);
        chk("reset_sd_addr", {14'd0, sd_addr}, 32'd0);
        rst = 0;

        rises0 = req_rises;
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].cs, vecs[i].addr, vecs[i].clr, vecs[i].ack, vecs[i].dst, vecs[i].din, 0);
            chk($sformatf("vec%0d_ok", i),      {31'd0, ok},      {31'd0, vecs[i].e_ok});
            chk($sformatf("vec%0d_dout", i),    dout,             vecs[i].e_dout);
            chk($sformatf("vec%0d_sd_req", i),  {31'd0, sd_req},  {31'd0, vecs[i].e_req});
            chk($sformatf("vec%0d_sd_addr", i), {14'd0, sd_addr}, {14'd0, vecs[i].e_saddr});
        end
        chk("miss_one_request", req_rises - rises0, 32'd1);

        // Two-entry hit: alternating addresses stay served every cycle
        fetch(18'h00101, 32'h11111111);
        rises0 = req_rises;
        for (int i = 0; i < 16; i++) begin
            step(1, (i % 2) ? 18'h00101 : 18'h00100, 0, 0, 0, '0, 1);
            chk("alt_ok",   {31'd0, ok}, 32'd1);
            chk("alt_dout", dout, (i % 2) ? 32'h11111111 : 32'hDEADBEEF);
        end
        chk("alt_no_request", req_rises - rises0, 32'd0);

        // LRU eviction: A, B, hit A, C replaces B
        fetch(18'h00200, 32'hA0A0A0A0);
        fetch(18'h00201, 32'hB0B0B0B0);
        step(1, 18'h00200, 0, 0, 0, '0, 1);
        fetch(18'h00202, 32'hC0C0C0C0);
        step(1, 18'h00200, 0, 0, 0, '0, 1);
        chk("lru_A_no_req", {31'd0, sd_req}, 32'd0);
        chk("lru_A_ok",     {31'd0, ok},     32'd1);
        chk("lru_A_dout",   dout,            32'hA0A0A0A0);
        step(1, 18'h00201, 0, 0, 0, '0, 1);
        chk("lru_B_req",    {31'd0, sd_req}, 32'd1);
        chk("lru_B_addr",   {14'd0, sd_addr}, {14'd0, 18'h00201});
        step(1, 18'h00201, 0, 1, 0, '0, 1);
        step(1, 18'h00201, 0, 0, 1, 32'hB0B0B0B0, 1);

        // Address change mid-fetch: cached B answered while A is in WAIT
        step(1, 18'h00300, 0, 0, 0, '0, 1);
        step(1, 18'h00300, 0, 1, 0, '0, 1);
        step(1, 18'h00201, 0, 0, 0, '0, 1);
        chk("mid_B_ok",   {31'd0, ok}, 32'd1);
        chk("mid_B_dout", dout,        32'hB0B0B0B0);
        step(1, 18'h00201, 0, 0, 1, 32'h30303030, 1);
        step(1, 18'h00300, 0, 0, 0, '0, 1);
        chk("mid_A_ok",     {31'd0, ok},     32'd1);
        chk("mid_A_dout",   dout,            32'h30303030);
        chk("mid_A_no_req", {31'd0, sd_req}, 32'd0);

        // clr on the same cycle as the data strobe
        step(1, 18'h00400, 0, 0, 0, '0, 1);
        step(1, 18'h00400, 0, 1, 0, '0, 1);
        step(1, 18'h00400, 1, 0, 1, 32'h40404040, 1);
        chk("clr_ok", {31'd0, ok}, 32'd0);
        step(1, 18'h00201, 0, 0, 0, '0, 1);
        chk("clr_B_invalid", {31'd0, ok}, 32'd0);
        chk("clr_refetch_req", {31'd0, sd_req}, 32'd1);
        chk("clr_refetch_addr", {14'd0, sd_addr}, {14'd0, 18'h00201});
        step(1, 18'h00201, 0, 1, 0, '0, 1);
        step(1, 18'h00201, 0, 0, 1, 32'hB1B1B1B1, 1);

        // Asynchronous reset between ack and data
        step(1, 18'h00500, 0, 0, 0, '0, 1);
        step(1, 18'h00500, 0, 1, 0, '0, 1);
        step(1, 18'h00201, 0, 0, 0, '0, 1);
        chk("arst_pre_ok", {31'd0, ok}, 32'd1);
        rst = 1;
        #2;
        chk("arst_ok",     {31'd0, ok},     32'd0);
        chk("arst_sd_req", {31'd0, sd_req}, 32'd0);
        chk("arst_dout",   dout,            32'd0);
        model_reset();
        #2;
        rst = 0;
        step(1, 18'h00201, 0, 0, 1, 32'h55555555, 1);
        chk("arst_late_dst_ok", {31'd0, ok}, 32'd0);
        step(1, 18'h00201, 0, 0, 0, '0, 1);
        chk("arst_no_valid_req", {31'd0, sd_req}, 32'd1);
        step(1, 18'h00201, 0, 1, 0, '0, 1);
        step(1, 18'h00201, 0, 0, 1, 32'hB2B2B2B2, 1);

        // Randomised traffic against the model, with a reactive SDRAM
        for (int i = 0; i < 1500; i++) begin
            ra   = 18'h00600 + 18'($urandom_range(0, 3));
            rc   = ($urandom_range(0, 9) != 0);
            rcl  = ($urandom_range(0, 39) == 0);
            rack = 0;
            rdst = 0;
            if (m_busy && !m_acked) begin
                rack = ($urandom_range(0, 2) == 0);
                rdst = rack ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 11) == 0);
            end else if (m_busy) begin
                rdst = ($urandom_range(0, 2) == 0);
            end else begin
                rdst = ($urandom_range(0, 49) == 0);
            end
            step(rc, ra, rcl, rack, rdst, $urandom, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jtkiwi_romcache.md
# jtkiwi_romcache

Two-entry read cache and SDRAM request sequencer between the kiwi video tile/sprite fetch ports (scr_addr/scr_cs/scr_data/scr_ok, obj_*) and one SDRAM bank slot. One instance serves each fetch port. It returns repeated 32-bit ROM words from local registers and issues one SDRAM request per miss. It holds the `ok` contract the gfx engine relies on: `ok` high only when `dout` matches the current `addr`.

## Interface
- AW, 18, word address width (byte address bits [19:2])
- DW, 32, data width
- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  invalidate both entries (ROM download or bank switch)
- cs  in  1  fetch request from gfx
- addr  in  AW  word address from gfx
- ok  out  1  dout valid for the current addr
- dout  out  DW  cached or fetched word
- sd_req  out  1  SDRAM request, level
- sd_addr  out  AW  SDRAM word address, stable while sd_req is high
- sd_ack  in  1  one-cycle strobe: request accepted
- sd_dst  in  1  one-cycle strobe: sd_din valid
- sd_din  in  DW  SDRAM read data

## Operation
- Storage: 2 entries, each holding valid, tag[AW-1:0] and data[DW-1:0]. One LRU bit names the entry to replace.
- Hit: cs high, and addr equals a valid tag, with no fill or clr on the same cycle.
  - Next cycle: dout is that entry's data and ok=1.
  - The LRU bit points to the other entry.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - On cs with a miss: latch fetch address fa=addr, drive sd_addr=fa, set sd_req=1, go to REQ.
  - A hit never leaves IDLE.
- REQ:
  - Hold sd_req=1 and sd_addr=fa.
  - On sd_ack: sd_req=0, go to WAIT.
  - If sd_dst arrives on the same cycle as sd_ack (or before it): treat as fill and go to IDLE.
- WAIT:
  - On sd_dst: write sd_din into the LRU entry, with tag=fa and valid=1.
  - The LRU bit then points to the other entry. Go to IDLE.
- Fill forwarding:
  - If addr==fa and cs=1 on the sd_dst cycle: dout=sd_din and ok=1 the next cycle.
  - Otherwise the word is only cached.
  - In IDLE the next cycle, a new miss starts a new fetch.
- Address change while in REQ/WAIT: the fetch completes and fills normally; ok stays 0 until addr hits.
- cs low:
  - ok=0 the next cycle and dout holds its last value.
  - An in-flight fetch completes and fills. No new request starts.
- clr:
  - Clears both valid bits the next cycle and forces ok=0.
  - A fill landing on the same cycle as clr is discarded (valid stays 0).
  - An in-flight request is not aborted; its data is discarded unless it arrives after clr deasserts.
- Tag compare: full AW bits, no partial match. Address wrap-around is irrelevant (no arithmetic on addr).

## Timing
- Reset values:
  - ok=0, dout=0, sd_req=0, sd_addr=0.
  - FSM=IDLE, both valid=0, LRU=0.
- Hit latency: 1 clock from addr/cs sampled to ok=1.
- Miss latency: 1 clock to sd_req, then SDRAM latency, then 1 clock after sd_dst to ok=1.
- sd_req rises registered, at most one request outstanding, never re-requested before sd_dst.
- ok is registered and drops to 0 the cycle after addr changes to a non-hitting address. ok is never high with stale data.
- Back-to-back hits on alternating addresses: ok stays high every cycle.

## Test plan
- Reset then miss:
  - Stimulus: release rst, cs=1, addr=0x00100; sd_ack 3 cycles after sd_req, sd_dst 2 cycles later with sd_din=0xDEADBEEF.
  - Required: sd_addr=0x00100, sd_req drops on ack; ok=1 and dout=0xDEADBEEF one cycle after sd_dst; exactly one request.
- Two-entry hit:
  - Stimulus: fill 0x00100 and 0x00101, then alternate addr every cycle for 16 cycles.
  - Required: no sd_req; ok=1 on every cycle; dout alternates between the correct words.
- LRU eviction:
  - Stimulus: fill A, fill B, hit A, then miss C.
  - Required: C replaces B; access B issues sd_req with sd_addr=B; access A does not.
- Address change mid-fetch:
  - Stimulus: miss A; addr switches to a cached B while in WAIT.
  - Required: ok=1 for B the next cycle; A fills on sd_dst; a later access to A hits with no request.
- clr against fill:
  - Stimulus: clr pulse on the same cycle as sd_dst.
  - Required: ok=0 and no valid entries; re-access of the same addr issues sd_req.
- Async reset mid-WAIT:
  - Stimulus: assert rst between sd_ack and sd_dst.
  - Required: sd_req=0 and ok=0 immediately (no clock needed); a late sd_dst is ignored and no entry becomes valid.
